// File: rtl/serial_bit_tx_pkg.sv
// Shared types, line levels and the parity helper for the bit-serial transmitter.
package serial_bit_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Words wider than this are not supported by the parity helper.
  localparam int PARITY_MAX_W = 64;

  function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/serial_bit_tx_bit_timer.sv
// Bit-period down-counter: bit_last marks the final cycle of a bit period,
// bit_first marks the edge that opens a new bit period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic bit_first,
  output logic bit_last
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] ZERO   = CW'(0);

  logic [CW-1:0] cnt_r;

  // Reload on accept and on every bit boundary, otherwise count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO;
    end else if (start || bit_last) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - ONE;
    end
  end

  assign bit_last  = (cnt_r == ZERO);
  assign bit_first = start || bit_last;

endmodule

// File: rtl/serial_bit_tx.sv
// Framed bit-serial transmitter: start, WIDTH data bits LSB first, optional
// parity, stop; emits an enable strobe for each data and parity bit.
module serial_bit_tx
  import serial_bit_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             D,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);

  tx_state_t        state_r;
  logic [WIDTH-1:0] shift_r;
  logic             par_r;
  logic [BW-1:0]    bitcnt_r;
  logic             accept_s;
  logic             bit_first_s;
  logic             bit_last_s;

  assign load_ready = (state_r == IDLE);
  assign accept_s   = load_valid && load_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (accept_s),
    .bit_first(bit_first_s),
    .bit_last (bit_last_s)
  );

  // Frame sequencer; D/en/busy/done are updated on the same edge as the state
  // so the line level always matches the bit being sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      shift_r  <= {WIDTH{1'b0}};
      par_r    <= 1'b0;
      bitcnt_r <= BIT_ZERO;
      D        <= LINE_IDLE;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shift_r  <= data_in;
            par_r    <= parity_of(PARITY_MAX_W'(data_in), PARITY_ODD);
            bitcnt_r <= BIT_ZERO;
            state_r  <= START;
            D        <= START_BIT;
            busy     <= 1'b1;
          end else begin
            D    <= LINE_IDLE;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_last_s) begin
            state_r  <= DATA;
            D        <= shift_r[0];
            shift_r  <= shift_r >> 1'b1;
            bitcnt_r <= BIT_ONE;
            en       <= bit_first_s;
          end
        end
        DATA: begin
          if (bit_last_s) begin
            if (bitcnt_r == LAST_BIT) begin
              if (PARITY_EN) begin
                state_r <= PARITY;
                D       <= par_r;
                en      <= bit_first_s;
              end else begin
                state_r <= STOP;
                D       <= STOP_BIT;
              end
            end else begin
              D        <= shift_r[0];
              shift_r  <= shift_r >> 1'b1;
              bitcnt_r <= bitcnt_r + BIT_ONE;
              en       <= bit_first_s;
            end
          end
        end
        PARITY: begin
          if (bit_last_s) begin
            state_r <= STOP;
            D       <= STOP_BIT;
          end
        end
        STOP: begin
          if (bit_last_s) begin
            state_r <= IDLE;
            D       <= LINE_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          D       <= LINE_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench: four transmitter configurations, each decoded by an
// enabled-D-flip-flop receiver model and compared against queued expectations.
module tb_serial_bit_tx;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         nen;
    int         len;
    int         gap;
  } exp_t;

  // u0: 8/4 even, u1: 8/4 odd, u2: 8/4 no parity, u3: 8/1 even
  localparam logic [3:0] PE_MASK = 4'b1011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [3:0] lv = 4'b0000;
  logic [3:0] rdy_w, d_w, en_w, busy_w, done_w;
  logic       end_req = 1'b0;

  int tests = 0;
  int fails = 0;

  exp_t       exp_q [4][$];
  exp_t       cur;
  logic [8:0] rx_sr  [4];
  int         nen_c  [4];
  int         len_c  [4];
  int         idle_c [4];
  logic       last_d [4];

  always #5 clk = ~clk;

  serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv[0]), .load_ready(rdy_w[0]),
    .D(d_w[0]), .en(en_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv[1]), .load_ready(rdy_w[1]),
    .D(d_w[1]), .en(en_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv[2]), .load_ready(rdy_w[2]),
    .D(d_w[2]), .en(en_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u3 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv[3]), .load_ready(rdy_w[3]),
    .D(d_w[3]), .en(en_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic chk(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: receiver model per DUT, popped and compared on every done pulse.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (reset) begin
        exp_q[g].delete();
        rx_sr[g]  = 9'h000;
        nen_c[g]  = 0;
        len_c[g]  = 0;
        idle_c[g] = 0;
        last_d[g] = 1'b1;
      end else begin
        chk(rdy_w[g] == !busy_w[g], $sformatf("u%0d_ready", g), int'(rdy_w[g]), int'(!busy_w[g]));
        if (!busy_w[g]) begin
          chk(d_w[g] == 1'b1, $sformatf("u%0d_idle_line", g), int'(d_w[g]), 1);
          idle_c[g]++;
        end else begin
          if (len_c[g] == 0) begin
            chk(d_w[g] == 1'b0, $sformatf("u%0d_start_bit", g), int'(d_w[g]), 0);
            if (exp_q[g].size() > 0 && exp_q[g][0].gap >= 0)
              chk(idle_c[g] == exp_q[g][0].gap, $sformatf("u%0d_gap", g), idle_c[g], exp_q[g][0].gap);
          end
          idle_c[g] = 0;
          len_c[g]++;
          last_d[g] = d_w[g];
          if (en_w[g]) begin
            rx_sr[g] = {d_w[g], rx_sr[g][8:1]};
            nen_c[g]++;
          end
        end
        if (done_w[g]) begin
          if (exp_q[g].size() == 0) begin
            chk(1'b0, $sformatf("u%0d_unexpected_done", g), 1, 0);
          end else begin
            cur = exp_q[g].pop_front();
            chk(len_c[g] == cur.len, $sformatf("u%0d_frame_len", g), len_c[g], cur.len);
            chk(nen_c[g] == cur.nen, $sformatf("u%0d_en_count", g), nen_c[g], cur.nen);
            chk(last_d[g] == 1'b1, $sformatf("u%0d_stop_bit", g), int'(last_d[g]), 1);
            if (PE_MASK[g])
              chk(rx_sr[g] == {cur.par, cur.data}, $sformatf("u%0d_rx_word", g),
                  int'(rx_sr[g]), int'({cur.par, cur.data}));
            else
              chk(rx_sr[g][8:1] == cur.data, $sformatf("u%0d_rx_word", g),
                  int'(rx_sr[g][8:1]), int'(cur.data));
          end
          rx_sr[g] = 9'h000;
          nen_c[g] = 0;
          len_c[g] = 0;
        end
      end
    end
    if (end_req) begin
      for (int g = 0; g < 4; g++)
        chk(exp_q[g].size() == 0, $sformatf("u%0d_pending", g), exp_q[g].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic push(input int g, input logic [7:0] w, input logic p, input int ne, input int ln,
                      input int gp);
    exp_t e;
    e.data = w; e.par = p; e.nen = ne; e.len = ln; e.gap = gp;
    exp_q[g].push_back(e);
  endtask

  task automatic wait_accept(input int g);
    int n = 0;
    @(negedge clk);
    while (!rdy_w[g]) begin
      n++;
      if (n > 200) begin
        $display("FAIL u%0d_accept_timeout: got no ready, expected ready within 200 cycles", g);
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    @(negedge clk);
    while (!done_w[g]) begin
      n++;
      if (n > 200) begin
        $display("FAIL u%0d_done_timeout: got no done, expected done within 200 cycles", g);
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input int g, input logic [7:0] w, input logic p, input int ne, input int ln,
                      input int gp);
    push(g, w, p, ne, ln, gp);
    @(posedge clk); #1;
    data_in = w;
    lv[g]   = 1'b1;
    wait_accept(g);
    @(posedge clk); #1;
    lv[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);

    // A5: 1,0,1,0,0,1,0,1 LSB first, four ones -> even parity 0
    send(0, 8'hA5, 1'b0, 9, 44, -1);
    wait_done(0);
    send(1, 8'h03, 1'b1, 9, 44, -1);
    wait_done(1);
    send(2, 8'h03, 1'b0, 8, 40, -1);
    wait_done(2);
    send(3, 8'hA5, 1'b0, 9, 11, -1);
    wait_done(3);

    // Back-to-back with load_valid held high
    push(0, 8'h3C, 1'b0, 9, 44, -1);
    @(posedge clk); #1;
    data_in = 8'h3C;
    lv[0]   = 1'b1;
    wait_accept(0);
    @(posedge clk); #1;
    data_in = 8'hC3;
    push(0, 8'hC3, 1'b0, 9, 44, 1);
    wait_done(0);
    @(posedge clk); #1;
    lv[0] = 1'b0;
    wait_done(0);

    // Reset during data bit 3, then a clean FF frame
    send(0, 8'h5A, 1'b0, 9, 44, -1);
    repeat (17) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    send(0, 8'hFF, 1'b0, 9, 44, -1);
    wait_done(0);

    // Reset together with a load: the word is discarded
    @(posedge clk); #1;
    reset   = 1'b1;
    data_in = 8'h77;
    lv[0]   = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lv[0] = 1'b0;
    repeat (10) @(posedge clk);

    // Inputs toggled while the frame is in flight
    send(0, 8'h96, 1'b0, 9, 44, -1);
    repeat (30) begin
      @(posedge clk); #1;
      data_in = 8'($urandom);
      lv[0]   = 1'($urandom_range(0, 1));
    end
    lv[0] = 1'b0;
    wait_done(0);

    repeat (5) @(posedge clk);
    #1 end_req = 1'b1;
  end

endmodule
